// File: rtl/voice_allocator.sv
// Polyphonic voice scheduler: maps note-on/off events onto NUM_VOICES gate/note channels.
// Optional damper pedal support is enabled with `define VOICE_ALLOCATOR_SUSTAIN_EN.
module voice_allocator #(
    parameter int unsigned NUM_VOICES = 4,
    parameter int unsigned NOTE_BITS  = 7,
    parameter int unsigned AGE_BITS   = 4
) (
    input  logic                             clock,
    input  logic                             reset_n,
    input  logic                             ev_valid,
    output logic                             ev_ready,
    input  logic                             ev_on,
    input  logic [NOTE_BITS-1:0]             ev_note,
    input  logic [NUM_VOICES-1:0]            voice_active,
`ifdef VOICE_ALLOCATOR_SUSTAIN_EN
    input  logic                             sustain,
`endif
    output logic [NUM_VOICES-1:0]            gate,
    output logic [NUM_VOICES*NOTE_BITS-1:0]  voice_note,
    output logic                             steal,
    output logic                             done
);

    localparam int unsigned IW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NUM_VOICES - 1);

    typedef enum logic [1:0] {IDLE, SCAN, GAP, COMMIT} state_t;

    state_t                state;
    logic [IW-1:0]         idx;
    logic                  on_q;
    logic [NOTE_BITS-1:0]  note_q;
    logic [NOTE_BITS-1:0]  notes [NUM_VOICES];
    logic [AGE_BITS-1:0]   ages  [NUM_VOICES];
    logic [NUM_VOICES-1:0] held;

    logic                  m_found, f_found, r_found, g_found;
    logic [IW-1:0]         m_idx, f_idx, r_idx, g_idx;
    logic [AGE_BITS-1:0]   r_age, g_age;
    logic [IW-1:0]         tgt;
    logic                  tgt_steal;

    logic                  m_found_n, f_found_n, r_found_n, g_found_n;
    logic [IW-1:0]         m_idx_n, f_idx_n, r_idx_n, g_idx_n;
    logic [AGE_BITS-1:0]   r_age_n, g_age_n;
    logic [IW-1:0]         tgt_n;
    logic                  tgt_gated_n, tgt_steal_n;

`ifdef VOICE_ALLOCATOR_SUSTAIN_EN
    logic sustain_q;
    logic release_pend;
`else
    assign held = '0;
`endif

    // Candidate update for the voice under scan; strict '>' keeps ties on the lower index.
    always_comb begin
        m_found_n = m_found;  m_idx_n = m_idx;
        f_found_n = f_found;  f_idx_n = f_idx;
        r_found_n = r_found;  r_idx_n = r_idx;  r_age_n = r_age;
        g_found_n = g_found;  g_idx_n = g_idx;  g_age_n = g_age;
        if (!m_found && gate[idx] && !held[idx] && notes[idx] == note_q) begin
            m_found_n = 1'b1;  m_idx_n = idx;
        end
        if (!f_found && !gate[idx] && !voice_active[idx]) begin
            f_found_n = 1'b1;  f_idx_n = idx;
        end
        if (!gate[idx] && voice_active[idx] && (!r_found || ages[idx] > r_age)) begin
            r_found_n = 1'b1;  r_idx_n = idx;  r_age_n = ages[idx];
        end
        if (gate[idx] && (!g_found || ages[idx] > g_age)) begin
            g_found_n = 1'b1;  g_idx_n = idx;  g_age_n = ages[idx];
        end
        tgt_n       = g_idx_n;
        tgt_gated_n = 1'b1;
        tgt_steal_n = 1'b1;
        if (m_found_n) begin
            tgt_n = m_idx_n;  tgt_gated_n = 1'b1;  tgt_steal_n = 1'b0;
        end else if (f_found_n) begin
            tgt_n = f_idx_n;  tgt_gated_n = 1'b0;  tgt_steal_n = 1'b0;
        end else if (r_found_n) begin
            tgt_n = r_idx_n;  tgt_gated_n = 1'b0;  tgt_steal_n = 1'b0;
        end
    end

    always_comb begin
        voice_note = '0;
        for (int unsigned i = 0; i < NUM_VOICES; i++)
            voice_note[i*NOTE_BITS +: NOTE_BITS] = notes[i];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            ev_ready  <= 1'b0;
            idx       <= '0;
            on_q      <= 1'b0;
            note_q    <= '0;
            gate      <= '0;
            steal     <= 1'b0;
            done      <= 1'b0;
            m_found   <= 1'b0;  m_idx <= '0;
            f_found   <= 1'b0;  f_idx <= '0;
            r_found   <= 1'b0;  r_idx <= '0;  r_age <= '0;
            g_found   <= 1'b0;  g_idx <= '0;  g_age <= '0;
            tgt       <= '0;
            tgt_steal <= 1'b0;
            for (int unsigned i = 0; i < NUM_VOICES; i++) begin
                notes[i] <= '0;
                ages[i]  <= '0;
            end
`ifdef VOICE_ALLOCATOR_SUSTAIN_EN
            held         <= '0;
            sustain_q    <= 1'b0;
            release_pend <= 1'b0;
`endif
        end else begin
            steal <= 1'b0;
            done  <= 1'b0;
`ifdef VOICE_ALLOCATOR_SUSTAIN_EN
            sustain_q <= sustain;
            if (sustain_q && !sustain && state != IDLE)
                release_pend <= 1'b1;
`endif
            case (state)
                IDLE: begin
                    ev_ready <= 1'b1;
`ifdef VOICE_ALLOCATOR_SUSTAIN_EN
                    if (release_pend || (sustain_q && !sustain)) begin
                        gate         <= gate & ~held;
                        held         <= '0;
                        release_pend <= 1'b0;
                    end
`endif
                    if (ev_valid && ev_ready) begin
                        on_q     <= ev_on;
                        note_q   <= ev_note;
                        idx      <= '0;
                        m_found  <= 1'b0;
                        f_found  <= 1'b0;
                        r_found  <= 1'b0;
                        g_found  <= 1'b0;
                        ev_ready <= 1'b0;
                        state    <= SCAN;
                    end
                end
                SCAN: begin
                    m_found <= m_found_n;  m_idx <= m_idx_n;
                    f_found <= f_found_n;  f_idx <= f_idx_n;
                    r_found <= r_found_n;  r_idx <= r_idx_n;  r_age <= r_age_n;
                    g_found <= g_found_n;  g_idx <= g_idx_n;  g_age <= g_age_n;
                    idx     <= idx + IW'(1);
                    if (idx == LAST) begin
                        tgt       <= tgt_n;
                        tgt_steal <= tgt_steal_n;
                        state     <= (on_q && tgt_gated_n) ? GAP : COMMIT;
                    end
                end
                // Drops the gate for the single COMMIT cycle so the envelope sees a fresh edge.
                GAP: begin
                    gate[tgt] <= 1'b0;
                    state     <= COMMIT;
                end
                COMMIT: begin
                    if (on_q) begin
                        gate[tgt]  <= 1'b1;
                        notes[tgt] <= note_q;
                        steal      <= tgt_steal;
`ifdef VOICE_ALLOCATOR_SUSTAIN_EN
                        held[tgt]  <= 1'b0;
`endif
                        for (int unsigned i = 0; i < NUM_VOICES; i++) begin
                            if (IW'(i) == tgt)
                                ages[i] <= '0;
                            else if (ages[i] != '1)
                                ages[i] <= ages[i] + AGE_BITS'(1);
                        end
                    end else if (m_found) begin
`ifdef VOICE_ALLOCATOR_SUSTAIN_EN
                        if (sustain)
                            held[m_idx] <= 1'b1;
                        else
                            gate[m_idx] <= 1'b0;
`else
                        gate[m_idx] <= 1'b0;
`endif
                    end
                    done     <= 1'b1;
                    ev_ready <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_voice_allocator.sv
// Scoreboard bench for voice_allocator (NUM_VOICES=4): stimulus queues expected results,
// a negedge monitor checks them whenever done pulses.
module tb_voice_allocator;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        ev_valid;
    logic        ev_ready;
    logic        ev_on;
    logic [6:0]  ev_note;
    logic [3:0]  voice_active;
    logic        sustain;
    logic [3:0]  gate;
    logic [27:0] voice_note;
    logic        steal;
    logic        done;

    voice_allocator #(.NUM_VOICES(4), .NOTE_BITS(7), .AGE_BITS(4)) dut (
        .clock(clock),
        .reset_n(reset_n),
        .ev_valid(ev_valid),
        .ev_ready(ev_ready),
        .ev_on(ev_on),
        .ev_note(ev_note),
        .voice_active(voice_active),
`ifdef VOICE_ALLOCATOR_SUSTAIN_EN
        .sustain(sustain),
`endif
        .gate(gate),
        .voice_note(voice_note),
        .steal(steal),
        .done(done)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0]  gate;
        logic [27:0] notes;
        logic        steal;
        int          lat;
        logic [3:0]  prev;
        time         t0;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [27:0] p(input logic [6:0] a, input logic [6:0] b,
                                      input logic [6:0] c, input logic [6:0] d);
        return {d, c, b, a};
    endfunction

    function automatic exp_t mk(input logic [3:0] g, input logic [27:0] n, input logic s,
                                input int l, input logic [3:0] pv);
        exp_t e;
        e.gate = g; e.notes = n; e.steal = s; e.lat = l; e.prev = pv; e.t0 = 0;
        return e;
    endfunction

    // Monitor: compares the DUT against the oldest expectation on every done pulse.
    initial begin
        exp_t       e;
        logic [3:0] gate_prev = '0;
        int         lat;
        forever begin
            @(negedge clock);
            if (reset_n) begin
                if (done) begin
                    if (sb.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL unexpected_done: got done=1 expected no pending event");
                    end else begin
                        e   = sb.pop_front();
                        lat = int'(($time - e.t0 - 5) / 10);
                        chk("gate", 32'(gate), 32'(e.gate));
                        chk("voice_note", 32'(voice_note), 32'(e.notes));
                        chk("steal", 32'(steal), 32'(e.steal));
                        chk("latency", lat, e.lat);
                        chk("gate_before_done", 32'(gate_prev), 32'(e.prev));
                    end
                end else if (steal) begin
                    tests++; fails++;
                    $display("FAIL stray_steal: got steal=1 without done expected 0");
                end
            end
            gate_prev = gate;
        end
    end

    task automatic send(input logic on, input logic [6:0] note, input exp_t e);
        int unsigned waited = 0;
        while (!ev_ready && waited < 50) begin
            @(negedge clock);
            waited++;
        end
        if (!ev_ready) begin
            chk("ready_timeout", 32'(ev_ready), 32'd1);
            return;
        end
        ev_valid = 1'b1; ev_on = on; ev_note = note;
        @(posedge clock);
        e.t0 = $time;
        sb.push_back(e);
        @(negedge clock);
        ev_valid = 1'b0;
        waited = 0;
        while (sb.size() != 0 && waited < 50) begin
            @(negedge clock);
            waited++;
        end
        if (sb.size() != 0) begin
            chk("done_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    initial begin
        reset_n = 1'b0; ev_valid = 1'b0; ev_on = 1'b0; ev_note = '0;
        voice_active = '0; sustain = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_gate", 32'(gate), 32'd0);
        chk("rst_voice_note", 32'(voice_note), 32'd0);
        chk("rst_ev_ready", 32'(ev_ready), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_steal", 32'(steal), 32'd0);
        reset_n = 1'b1;
        @(negedge clock);
        chk("ready_after_reset", 32'(ev_ready), 32'd1);

        // Fill all four voices, then steal the oldest.
        send(1'b1, 7'd60, mk(4'b0001, p(60, 0, 0, 0), 1'b0, 5, 4'b0000));
        send(1'b1, 7'd62, mk(4'b0011, p(60, 62, 0, 0), 1'b0, 5, 4'b0001));
        send(1'b1, 7'd64, mk(4'b0111, p(60, 62, 64, 0), 1'b0, 5, 4'b0011));
        send(1'b1, 7'd67, mk(4'b1111, p(60, 62, 64, 67), 1'b0, 5, 4'b0111));
        send(1'b1, 7'd72, mk(4'b1111, p(72, 62, 64, 67), 1'b1, 6, 4'b1110));

        // Note-offs: matching, non-matching, then free voice 3.
        send(1'b0, 7'd62, mk(4'b1101, p(72, 62, 64, 67), 1'b0, 5, 4'b1111));
        send(1'b0, 7'd50, mk(4'b1101, p(72, 62, 64, 67), 1'b0, 5, 4'b1101));
        send(1'b0, 7'd67, mk(4'b0101, p(72, 62, 64, 67), 1'b0, 5, 4'b1101));

        // Voice 1 releasing: free voice 3 wins, then the releasing voice is taken.
        voice_active = 4'b0010;
        send(1'b1, 7'd70, mk(4'b1101, p(72, 62, 64, 70), 1'b0, 5, 4'b0101));
        send(1'b1, 7'd74, mk(4'b1111, p(72, 74, 64, 70), 1'b0, 5, 4'b1101));
        voice_active = 4'b0000;

        // Retrigger of a matching voice, then a steal of the oldest (voice 0).
        send(1'b1, 7'd64, mk(4'b1111, p(72, 74, 64, 70), 1'b0, 6, 4'b1011));
        send(1'b1, 7'd76, mk(4'b1111, p(76, 74, 64, 70), 1'b1, 6, 4'b1110));

        // Repeated retriggers saturate voices 1..3 at age 15; the tie then goes to voice 1.
        for (int i = 0; i < 14; i++)
            send(1'b1, 7'd76, mk(4'b1111, p(76, 74, 64, 70), 1'b0, 6, 4'b1110));
        send(1'b1, 7'd80, mk(4'b1111, p(76, 80, 64, 70), 1'b1, 6, 4'b1101));

`ifdef VOICE_ALLOCATOR_SUSTAIN_EN
        sustain = 1'b1;
        send(1'b0, 7'd76, mk(4'b1111, p(76, 80, 64, 70), 1'b0, 5, 4'b1111));
        sustain = 1'b0;
        @(negedge clock);
        chk("sustain_release_gate", 32'(gate), 32'(4'b1110));
        send(1'b0, 7'd76, mk(4'b1110, p(76, 80, 64, 70), 1'b0, 5, 4'b1110));
`endif

        // Reset during SCAN discards the event.
        ev_valid = 1'b1; ev_on = 1'b1; ev_note = 7'd90;
        @(posedge clock);
        @(negedge clock);
        ev_valid = 1'b0;
        @(negedge clock);
        #1 reset_n = 1'b0;
        #1;
        chk("midscan_rst_gate", 32'(gate), 32'd0);
        chk("midscan_rst_voice_note", 32'(voice_note), 32'd0);
        chk("midscan_rst_ev_ready", 32'(ev_ready), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        chk("midscan_ready_after_release", 32'(ev_ready), 32'd1);
        send(1'b1, 7'd60, mk(4'b0001, p(60, 0, 0, 0), 1'b0, 5, 4'b0000));

        repeat (4) @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
